// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter.
// Optional feature macro used by this slice: STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {StRun, StPause, StAdjust} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        ONES_MAX = 4'd9;
    localparam int unsigned TENS_MAX = 5;

    // blankMask bit positions
    localparam int unsigned BLANK_MIN_TENS = 3;
    localparam int unsigned BLANK_MIN_ONES = 2;
    localparam int unsigned BLANK_SEC_TENS = 1;
    localparam int unsigned BLANK_SEC_ONES = 0;

    typedef struct packed {
        logic wrap;
        bcd_t tens;
        bcd_t ones;
    } field_t;

    // One BCD step of a two-digit field; wrap flags the tens_max9 -> 00 rollover.
    function automatic field_t field_inc(input bcd_t tens, input bcd_t ones, input bcd_t tens_max);
        field_t r;
        r.wrap = 1'b0;
        r.tens = tens;
        r.ones = ones + 4'd1;
        if (ones >= ONES_MAX) begin
            r.ones = '0;
            if (tens >= tens_max) begin
                r.tens = '0;
                r.wrap = 1'b1;
            end else begin
                r.tens = tens + 4'd1;
            end
        end
        return r;
    endfunction

    // Selected field blinks in adjust mode; everything else stays lit.
    function automatic logic [3:0] blank_mask(input logic adj, input logic phase,
                                              input logic sel_sec);
        logic [3:0] m;
        m = '0;
        if (adj) begin
            if (sel_sec) begin
                m[BLANK_SEC_TENS] = phase;
                m[BLANK_SEC_ONES] = phase;
            end else begin
                m[BLANK_MIN_TENS] = phase;
                m[BLANK_MIN_ONES] = phase;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Divider/button inputs and display outputs of the stopwatch counter.
// lapBtn exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic       incClk;
    logic       adjClk;
    logic       blinkClk;
    logic       pauseBtn;
    logic       adjSw;
    logic       selSw;
`ifdef STOPWATCH_LAP_EN
    logic       lapBtn;
`endif
    bcd_t       minTens;
    bcd_t       minOnes;
    bcd_t       secTens;
    bcd_t       secOnes;
    logic [3:0] blankMask;
    logic       running;

    modport master (
`ifdef STOPWATCH_LAP_EN
        output lapBtn,
`endif
        output incClk, adjClk, blinkClk, pauseBtn, adjSw, selSw,
        input  minTens, minOnes, secTens, secOnes, blankMask, running
    );

    modport slave (
`ifdef STOPWATCH_LAP_EN
        input  lapBtn,
`endif
        input  incClk, adjClk, blinkClk, pauseBtn, adjSw, selSw,
        output minTens, minOnes, secTens, secOnes, blankMask, running
    );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer with optional rising-edge pulse output.
// EdgeDetect = 0 returns the synchronized level instead of the pulse.
module edge_sync #(
    parameter bit EdgeDetect = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Bring the asynchronous input into the i_clk domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    if (EdgeDetect) begin : g_edge
        logic r_prev;

        // Remember last synchronized level for the rising-edge compare.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_prev <= 1'b0;
            end else begin
                r_prev <= r_sync;
            end
        end

        assign o_q = r_sync & ~r_prev;
    end else begin : g_level
        assign o_q = r_sync;
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS counter with run, pause and adjust modes.
// Define STOPWATCH_LAP_EN to add the lapBtn display-freeze feature.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_TENS = TENS_MAX
) (
    input logic                masterClk,
    input logic                rst,
    stopwatch_counter_if.slave bus
);

    localparam bcd_t TensLim = bcd_t'(MAX_TENS);

    logic   w_inc, w_adj, w_blink, w_pause, w_adj_sw, w_sel;
    state_t r_state, r_resume;
    state_t w_state_d, w_resume_d;
    logic   r_blink, w_blink_d, w_enter_adj;
    logic   r_running;
    logic [3:0] r_blank;
    bcd_t   r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    field_t w_sec_inc, w_min_inc;

    edge_sync #(.EdgeDetect(1'b1)) u_sync_inc (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.incClk), .o_q(w_inc));
    edge_sync #(.EdgeDetect(1'b1)) u_sync_adj (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.adjClk), .o_q(w_adj));
    edge_sync #(.EdgeDetect(1'b1)) u_sync_blink (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.blinkClk), .o_q(w_blink));
    edge_sync #(.EdgeDetect(1'b1)) u_sync_pause (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.pauseBtn), .o_q(w_pause));
    edge_sync #(.EdgeDetect(1'b0)) u_sync_adj_sw (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.adjSw), .o_q(w_adj_sw));
    edge_sync #(.EdgeDetect(1'b0)) u_sync_sel (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.selSw), .o_q(w_sel));

    // Next mode, resume target and blink phase.
    always_comb begin
        w_state_d   = r_state;
        w_resume_d  = r_resume;
        w_enter_adj = 1'b0;
        w_blink_d   = r_blink ^ w_blink;
        unique case (r_state)
            StRun, StPause: begin
                if (w_adj_sw) begin
                    w_state_d   = StAdjust;
                    w_enter_adj = 1'b1;
                    // A coincident pause press flips the remembered state.
                    if (w_pause) begin
                        w_resume_d = (r_state == StRun) ? StPause : StRun;
                    end else begin
                        w_resume_d = r_state;
                    end
                end else if (w_pause) begin
                    w_state_d = (r_state == StRun) ? StPause : StRun;
                end
            end
            StAdjust: begin
                if (w_pause) begin
                    w_resume_d = (r_resume == StRun) ? StPause : StRun;
                end
                if (!w_adj_sw) begin
                    w_state_d = w_resume_d;
                end
            end
            default: w_state_d = StRun;
        endcase
        if (w_enter_adj) begin
            w_blink_d = 1'b0;
        end
    end

    // Mode FSM with registered running flag and blank mask.
    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            r_state   <= StRun;
            r_resume  <= StRun;
            r_blink   <= 1'b0;
            r_running <= 1'b1;
            r_blank   <= 4'b0000;
        end else begin
            r_state   <= w_state_d;
            r_resume  <= w_resume_d;
            r_blink   <= w_blink_d;
            r_running <= (w_state_d == StRun);
            r_blank   <= blank_mask(w_state_d == StAdjust, w_blink_d, w_sel);
        end
    end

    // Candidate increments for each field.
    always_comb begin
        w_sec_inc = field_inc(r_sec_tens, r_sec_ones, TensLim);
        w_min_inc = field_inc(r_min_tens, r_min_ones, TensLim);
    end

    // Seconds carry into minutes when running; adjust steps one field without carry.
    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
        end else if (r_state == StRun && w_inc) begin
            r_sec_tens <= w_sec_inc.tens;
            r_sec_ones <= w_sec_inc.ones;
            if (w_sec_inc.wrap) begin
                r_min_tens <= w_min_inc.tens;
                r_min_ones <= w_min_inc.ones;
            end
        end else if (r_state == StAdjust && w_adj) begin
            if (w_sel) begin
                r_sec_tens <= w_sec_inc.tens;
                r_sec_ones <= w_sec_inc.ones;
            end else begin
                r_min_tens <= w_min_inc.tens;
                r_min_ones <= w_min_inc.ones;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        w_lap;
    logic        r_lap_hold;
    logic [15:0] r_snap;

    edge_sync #(.EdgeDetect(1'b1)) u_sync_lap (
        .i_clk(masterClk), .i_rst(rst), .i_d(bus.lapBtn), .o_q(w_lap));

    // Lap toggles a frozen snapshot of the count; entering adjust releases it.
    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            r_lap_hold <= 1'b0;
            r_snap     <= '0;
        end else if (w_enter_adj) begin
            r_lap_hold <= 1'b0;
        end else if (w_lap) begin
            r_lap_hold <= ~r_lap_hold;
            r_snap     <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
        end
    end

    assign bus.minTens = r_lap_hold ? r_snap[15:12] : r_min_tens;
    assign bus.minOnes = r_lap_hold ? r_snap[11:8]  : r_min_ones;
    assign bus.secTens = r_lap_hold ? r_snap[7:4]   : r_sec_tens;
    assign bus.secOnes = r_lap_hold ? r_snap[3:0]   : r_sec_ones;
`else
    assign bus.minTens = r_min_tens;
    assign bus.minOnes = r_min_ones;
    assign bus.secTens = r_sec_tens;
    assign bus.secOnes = r_sec_ones;
`endif

    assign bus.blankMask = r_blank;
    assign bus.running   = r_running;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter (STOPWATCH_LAP_EN optional).
`timescale 1ns/1ps
module tb_stopwatch_counter;

    localparam int P_INC   = 0;
    localparam int P_ADJ   = 1;
    localparam int P_BLINK = 2;
    localparam int P_PAUSE = 3;
    localparam int P_LAP   = 4;

    logic masterClk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stopwatch_counter_if bus ();

    stopwatch_counter #(.MAX_TENS(5)) dut (
        .masterClk(masterClk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 masterClk = ~masterClk;

    function automatic logic [15:0] disp();
        disp = {bus.minTens, bus.minOnes, bus.secTens, bus.secOnes};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge masterClk);
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            P_INC:   bus.incClk   = v;
            P_ADJ:   bus.adjClk   = v;
            P_BLINK: bus.blinkClk = v;
            P_PAUSE: bus.pauseBtn = v;
`ifdef STOPWATCH_LAP_EN
            P_LAP:   bus.lapBtn   = v;
`endif
            default: ;
        endcase
    endtask

    // 3 cycles high, 3 low: update has landed by the time this returns.
    task automatic pulse(input int which);
        drive(which, 1'b1);
        idle(3);
        drive(which, 1'b0);
        idle(3);
    endtask

    task automatic do_reset();
        bus.incClk = 0; bus.adjClk = 0; bus.blinkClk = 0; bus.pauseBtn = 0;
        bus.adjSw = 0; bus.selSw = 0;
`ifdef STOPWATCH_LAP_EN
        bus.lapBtn = 0;
`endif
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    // Load a time from 00:00 through adjust mode, ending back in RUN.
    task automatic set_time(input int mm, input int ss);
        bus.selSw = 0;
        bus.adjSw = 1;
        idle(4);
        repeat (mm) pulse(P_ADJ);
        bus.selSw = 1;
        idle(3);
        repeat (ss) pulse(P_ADJ);
        bus.adjSw = 0;
        bus.selSw = 0;
        idle(4);
    endtask

    task automatic test_reset();
        bus.incClk = 0; bus.adjClk = 0; bus.blinkClk = 0; bus.pauseBtn = 0;
        bus.adjSw = 0; bus.selSw = 0;
`ifdef STOPWATCH_LAP_EN
        bus.lapBtn = 0;
`endif
        rst = 1'b1;
        #2;
        checks++; if (disp() !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", disp()); end
        checks++; if (bus.blankMask !== 4'b0000) begin errors++; $display("FAIL reset_blank got %b want 0000", bus.blankMask); end
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL reset_running got %b want 1", bus.running); end
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_run();
        repeat (65) pulse(P_INC);
        checks++; if (disp() !== 16'h0105) begin errors++; $display("FAIL run_65 got %h want 0105", disp()); end
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL run_running got %b want 1", bus.running); end
        checks++; if (bus.blankMask !== 4'b0000) begin errors++; $display("FAIL run_blank got %b want 0000", bus.blankMask); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_time(59, 59);
        checks++; if (disp() !== 16'h5959) begin errors++; $display("FAIL wrap_preload got %h want 5959", disp()); end
        bus.incClk = 1;
        @(posedge masterClk);
        @(posedge masterClk);
        #1;
        checks++; if (disp() !== 16'h5959) begin errors++; $display("FAIL wrap_early got %h want 5959", disp()); end
        @(posedge masterClk);
        #1;
        checks++; if (disp() !== 16'h0000) begin errors++; $display("FAIL wrap_edge3 got %h want 0000", disp()); end
        idle(2);
        bus.incClk = 0;
        idle(3);
    endtask

    task automatic test_pause();
        pulse(P_PAUSE);
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", bus.running); end
        repeat (10) pulse(P_INC);
        checks++; if (disp() !== 16'h0000) begin errors++; $display("FAIL pause_hold got %h want 0000", disp()); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL pause_still got %b want 0", bus.running); end
        pulse(P_PAUSE);
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL resume_running got %b want 1", bus.running); end
        repeat (3) pulse(P_INC);
        checks++; if (disp() !== 16'h0003) begin errors++; $display("FAIL resume_count got %h want 0003", disp()); end
    endtask

    task automatic test_adjust();
        do_reset();
        set_time(58, 10);
        checks++; if (disp() !== 16'h5810) begin errors++; $display("FAIL adj_preload got %h want 5810", disp()); end
        bus.selSw = 0;
        bus.adjSw = 1;
        idle(4);
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL adj_running got %b want 0", bus.running); end
        checks++; if (bus.blankMask !== 4'b0000) begin errors++; $display("FAIL adj_blank0 got %b want 0000", bus.blankMask); end
        pulse(P_BLINK);
        checks++; if (bus.blankMask !== 4'b1100) begin errors++; $display("FAIL adj_blink1 got %b want 1100", bus.blankMask); end
        pulse(P_BLINK);
        checks++; if (bus.blankMask !== 4'b0000) begin errors++; $display("FAIL adj_blink2 got %b want 0000", bus.blankMask); end
        pulse(P_INC);
        checks++; if (disp() !== 16'h5810) begin errors++; $display("FAIL adj_inc_ignored got %h want 5810", disp()); end
        repeat (3) pulse(P_ADJ);
        checks++; if (disp() !== 16'h0110) begin errors++; $display("FAIL adj_min_wrap got %h want 0110", disp()); end
        bus.selSw = 1;
        idle(3);
        pulse(P_BLINK);
        checks++; if (bus.blankMask !== 4'b0011) begin errors++; $display("FAIL adj_blink_sec got %b want 0011", bus.blankMask); end
        bus.adjSw = 0;
        bus.selSw = 0;
        idle(4);
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL adj_exit_running got %b want 1", bus.running); end
        checks++; if (bus.blankMask !== 4'b0000) begin errors++; $display("FAIL adj_exit_blank got %b want 0000", bus.blankMask); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_time(0, 59);
        bus.selSw = 1;
        bus.adjSw = 1;
        idle(4);
        bus.incClk = 1;
        bus.adjClk = 1;
        idle(3);
        bus.incClk = 0;
        bus.adjClk = 0;
        idle(3);
        checks++; if (disp() !== 16'h0000) begin errors++; $display("FAIL simul_inc_adj got %h want 0000", disp()); end
        // Pause while adjusting retargets the return state to PAUSE.
        pulse(P_PAUSE);
        bus.adjSw = 0;
        idle(4);
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL adj_resume_pause got %b want 0", bus.running); end
        pulse(P_PAUSE);
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL adj_resume_run got %b want 1", bus.running); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_time(12, 34);
        checks++; if (disp() !== 16'h1234) begin errors++; $display("FAIL areset_preload got %h want 1234", disp()); end
        @(posedge masterClk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (disp() !== 16'h0000) begin errors++; $display("FAIL areset_digits got %h want 0000", disp()); end
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL areset_running got %b want 1", bus.running); end
        idle(2);
        rst = 1'b0;
        idle(2);
        pulse(P_INC);
        checks++; if (disp() !== 16'h0001) begin errors++; $display("FAIL areset_resume got %h want 0001", disp()); end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        do_reset();
        repeat (7) pulse(P_INC);
        pulse(P_LAP);
        checks++; if (disp() !== 16'h0007) begin errors++; $display("FAIL lap_freeze got %h want 0007", disp()); end
        repeat (5) pulse(P_INC);
        checks++; if (disp() !== 16'h0007) begin errors++; $display("FAIL lap_held got %h want 0007", disp()); end
        pulse(P_LAP);
        checks++; if (disp() !== 16'h0012) begin errors++; $display("FAIL lap_release got %h want 0012", disp()); end
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_wrap();
        test_pause();
        test_adjust();
        test_simultaneous();
        test_async_reset();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
